// File: rtl/arm_pkg.sv
// -----------------------------------------------------------------------------
// arm_pkg
// Shared definitions for the pipeline memory stage and its SRAM interface.
//   - mem_state_e        : memory-stage FSM state encoding
//   - SRAM_ADDR_LEN_DEF  : default SRAM halfword address width
//   - WAIT_CYCLES_DEF    : default cycles spent on each SRAM halfword access
//   - BASE_ADDR_DEF      : default CPU byte address that maps to SRAM word 0
//   - CNT_W              : wait counter width (covers WAIT_CYCLES up to 15)
// -----------------------------------------------------------------------------
package arm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } mem_state_e;

    localparam int SRAM_ADDR_LEN_DEF = 18;
    localparam int WAIT_CYCLES_DEF   = 3;
    localparam int BASE_ADDR_DEF     = 1024;
    localparam int CNT_W             = 4;

endpackage : arm_pkg

// File: rtl/mem_stage_sram.sv
// -----------------------------------------------------------------------------
// mem_stage_sram
// Memory stage of the pipeline, backed by a 16-bit-wide external SRAM.
// Each 32-bit load or store is split into two halfword accesses: the LOW
// phase moves bits [15:0] and the HIGH phase moves bits [31:16]. Each phase
// lasts WAIT_CYCLES clocks. While an access is in flight, ready is held low
// so the rest of the pipeline freezes and keeps presenting the same request.
//
// Ports
//   clk          in   clock, all state updates on the rising edge
//   rst          in   asynchronous active-low reset
//   MEM_R_EN     in   load request
//   MEM_W_EN     in   store request (wins over MEM_R_EN when both are high)
//   ALU_Res      in   CPU byte address
//   Val_Rm       in   store data
//   MEM_Result   out  load data, updated only when a load completes
//   ready        out  low = freeze all upstream pipeline registers
//   SRAM_ADDR    out  SRAM halfword address
//   SRAM_DQ_out  out  SRAM write data
//   SRAM_DQ_oe   out  SRAM write-data drive enable
//   SRAM_DQ_in   in   SRAM read data
//   SRAM_WE_N    out  active-low SRAM write strobe
//   dbg_state    out  current FSM state, for observation only
// -----------------------------------------------------------------------------
module mem_stage_sram
    import arm_pkg::*;
#(
    parameter int DATA_LEN      = 32,
    parameter int ADDRESS_LEN   = 32,
    parameter int SRAM_ADDR_LEN = SRAM_ADDR_LEN_DEF,
    parameter int WAIT_CYCLES   = WAIT_CYCLES_DEF,
    parameter int BASE_ADDR     = BASE_ADDR_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     MEM_R_EN,
    input  logic                     MEM_W_EN,
    input  logic [ADDRESS_LEN-1:0]   ALU_Res,
    input  logic [DATA_LEN-1:0]      Val_Rm,
    output logic [DATA_LEN-1:0]      MEM_Result,
    output logic                     ready,
    output logic [SRAM_ADDR_LEN-1:0] SRAM_ADDR,
    output logic [15:0]              SRAM_DQ_out,
    output logic                     SRAM_DQ_oe,
    input  logic [15:0]              SRAM_DQ_in,
    output logic                     SRAM_WE_N,
    output mem_state_e               dbg_state
);

    localparam int WORD_W = SRAM_ADDR_LEN - 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

    // Flops
    mem_state_e               state_q,  state_d;
    logic [CNT_W-1:0]         cnt_q,    cnt_d;
    logic                     store_q,  store_d;
    logic [15:0]              lo_q,     lo_d;
    logic [DATA_LEN-1:0]      result_q, result_d;
    logic [SRAM_ADDR_LEN-1:0] addr_q,   addr_d;
    logic [15:0]              dq_q,     dq_d;
    logic                     oe_q,     oe_d;
    logic                     we_n_q,   we_n_d;

    logic                     req;
    logic                     last_cycle;
    logic [ADDRESS_LEN-1:0]   offset;
    logic [WORD_W-1:0]        word;

    assign req        = MEM_R_EN | MEM_W_EN;
    assign last_cycle = (cnt_q == LAST_CNT);

    // Addresses below BASE_ADDR or beyond the SRAM simply wrap: the
    // subtraction is modular and the shifted offset is truncated to the
    // SRAM word width.
    assign offset = ALU_Res - ADDRESS_LEN'(BASE_ADDR);
    assign word   = WORD_W'(offset >> 2);

    // Handshake: ready is a combinational stall signal toward the pipeline.
    // It is high only when this stage can accept or has just finished the
    // presented request: in IDLE with no request, and in DONE. A request seen
    // in IDLE drops ready in that same cycle; the upstream registers then hold
    // the request stable until the DONE cycle, where it is deliberately not
    // re-accepted because it is still the same instruction.
    assign ready = (state_q == ST_DONE) || ((state_q == ST_IDLE) && !req);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        store_d  = store_q;
        lo_d     = lo_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                    store_d = MEM_W_EN;
                end
            end
            ST_LOW: begin
                if (last_cycle) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                    if (!store_q) begin
                        lo_d = SRAM_DQ_in;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HIGH: begin
                if (last_cycle) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    if (!store_q) begin
                        result_d = DATA_LEN'({SRAM_DQ_in, lo_q});
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // SRAM pins are registered, so they are computed from the next state and
    // next counter value; this lines them up exactly with the phase cycles.
    // The write strobe rises on the last cycle of each phase so data and
    // address are still held stable when the write ends.
    always_comb begin
        addr_d = '0;
        dq_d   = '0;
        oe_d   = 1'b0;
        we_n_d = 1'b1;
        if ((state_d == ST_LOW) || (state_d == ST_HIGH)) begin
            addr_d = {word, (state_d == ST_HIGH)};
            dq_d   = (state_d == ST_HIGH) ? Val_Rm[31:16] : Val_Rm[15:0];
            oe_d   = store_d;
            we_n_d = !(store_d && (cnt_d != LAST_CNT));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            store_q  <= 1'b0;
            lo_q     <= '0;
            result_q <= '0;
            addr_q   <= '0;
            dq_q     <= '0;
            oe_q     <= 1'b0;
            we_n_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            store_q  <= store_d;
            lo_q     <= lo_d;
            result_q <= result_d;
            addr_q   <= addr_d;
            dq_q     <= dq_d;
            oe_q     <= oe_d;
            we_n_q   <= we_n_d;
        end
    end

    assign MEM_Result  = result_q;
    assign SRAM_ADDR   = addr_q;
    assign SRAM_DQ_out = dq_q;
    assign SRAM_DQ_oe  = oe_q;
    assign SRAM_WE_N   = we_n_q;
    assign dbg_state   = state_q;

endmodule : mem_stage_sram

// File: tb/tb_mem_stage_sram.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_sram
// Directed bench for mem_stage_sram with default parameters
// (WAIT_CYCLES = 3, BASE_ADDR = 1024, SRAM_ADDR_LEN = 18).
// Inputs change 2 time units after each rising edge; outputs are checked
// 1 time unit later, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_mem_stage_sram;
    import arm_pkg::*;

    localparam int W = 3;

    logic        clk;
    logic        rst;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] alu_res;
    logic [31:0] val_rm;
    logic [31:0] mem_result;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;
    mem_state_e  dbg_state;

    logic [15:0] sram_lo;
    logic [15:0] sram_hi;

    int total;
    int bad;

    mem_stage_sram dut (
        .clk        (clk),
        .rst        (rst),
        .MEM_R_EN   (mem_r_en),
        .MEM_W_EN   (mem_w_en),
        .ALU_Res    (alu_res),
        .Val_Rm     (val_rm),
        .MEM_Result (mem_result),
        .ready      (ready),
        .SRAM_ADDR  (sram_addr),
        .SRAM_DQ_out(sram_dq_out),
        .SRAM_DQ_oe (sram_dq_oe),
        .SRAM_DQ_in (sram_dq_in),
        .SRAM_WE_N  (sram_we_n),
        .dbg_state  (dbg_state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tiny SRAM model: odd halfword address returns the upper half.
    assign sram_dq_in = sram_addr[0] ? sram_hi : sram_lo;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_idle_pins(input string tag);
        check({tag, " we_n"}, 32'(sram_we_n), 32'd1);
        check({tag, " oe"},   32'(sram_dq_oe), 32'd0);
        check({tag, " addr"}, 32'(sram_addr), 32'd0);
        check({tag, " dq"},   32'(sram_dq_out), 32'd0);
    endtask

    // Presents one request in IDLE and checks every cycle through DONE.
    // The request stays asserted in DONE, as a frozen pipeline would hold it.
    task automatic access(input string tag, input logic r, input logic w,
                          input logic [31:0] alu, input logic [31:0] val,
                          input logic [16:0] word, input logic [15:0] lo,
                          input logic [15:0] hi, input logic [31:0] exp_res);
        logic [17:0] exp_addr;
        logic [15:0] exp_dq;
        mem_r_en = r;
        mem_w_en = w;
        alu_res  = alu;
        val_rm   = val;
        sram_lo  = lo;
        sram_hi  = hi;
        #1;
        check({tag, " t ready"}, 32'(ready), 32'd0);
        check({tag, " t state"}, 32'(dbg_state), 32'(ST_IDLE));
        for (int ph = 0; ph < 2; ph++) begin
            exp_addr = {word, ph[0]};
            exp_dq   = (ph == 1) ? val[31:16] : val[15:0];
            for (int c = 0; c < W; c++) begin
                tick();
                #1;
                check({tag, " ph ready"}, 32'(ready), 32'd0);
                check({tag, " ph addr"},  32'(sram_addr), 32'(exp_addr));
                check({tag, " ph dq"},    32'(sram_dq_out), 32'(exp_dq));
                check({tag, " ph oe"},    32'(sram_dq_oe), 32'(w));
                check({tag, " ph we_n"},  32'(sram_we_n), (w && c < W - 1) ? 32'd0 : 32'd1);
            end
        end
        tick();
        #1;
        check({tag, " done ready"},  32'(ready), 32'd1);
        check({tag, " done state"},  32'(dbg_state), 32'(ST_DONE));
        check({tag, " done result"}, mem_result, exp_res);
        check_idle_pins({tag, " done"});
    endtask

    task automatic drop_request(input string tag);
        tick();
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        #1;
        check({tag, " idle ready"}, 32'(ready), 32'd1);
        check({tag, " idle state"}, 32'(dbg_state), 32'(ST_IDLE));
        check_idle_pins({tag, " idle"});
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b0;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        alu_res  = 32'd0;
        val_rm   = 32'd0;
        sram_lo  = 16'h0;
        sram_hi  = 16'h0;

        // Reset state
        tick();
        tick();
        #1;
        check("reset ready",  32'(ready), 32'd1);
        check("reset state",  32'(dbg_state), 32'(ST_IDLE));
        check("reset result", mem_result, 32'd0);
        check_idle_pins("reset");
        rst = 1'b1;

        // Idle with no request holds IDLE
        tick();
        #1;
        check("hold ready", 32'(ready), 32'd1);
        tick();
        #1;
        check("hold state", 32'(dbg_state), 32'(ST_IDLE));

        // Store 0xDEADBEEF at 1028 -> word 1, halfwords 2 and 3
        tick();
        access("store", 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 17'h1,
               16'hAAAA, 16'h5555, 32'h0);
        drop_request("store");

        // Load from 1028 -> 0xDEADBEEF
        tick();
        access("load", 1'b1, 1'b0, 32'd1028, 32'h0, 17'h1,
               16'hBEEF, 16'hDEAD, 32'hDEADBEEF);
        drop_request("load");

        // Both enables: behaves as a store, result unchanged
        tick();
        access("both", 1'b1, 1'b1, 32'd1028, 32'h12345678, 17'h1,
               16'hAAAA, 16'h5555, 32'hDEADBEEF);
        drop_request("both");

        // Address below BASE_ADDR wraps to the top word
        tick();
        access("wrap", 1'b1, 1'b0, 32'd1020, 32'h0, 17'h1FFFF,
               16'h1111, 16'h2222, 32'h22221111);
        drop_request("wrap");

        // Back-to-back loads: request held through DONE, next access starts
        // from IDLE (the first cycle of the second access checks IDLE)
        tick();
        access("b2b1", 1'b1, 1'b0, 32'd1032, 32'h0, 17'h2,
               16'h3333, 16'h4444, 32'h44443333);
        tick();
        access("b2b2", 1'b1, 1'b0, 32'd1036, 32'h0, 17'h3,
               16'h6666, 16'h7777, 32'h77776666);
        drop_request("b2b");

        // Reset during the HIGH phase of a store
        tick();
        mem_w_en = 1'b1;
        alu_res  = 32'd1028;
        val_rm   = 32'hCAFEF00D;
        for (int i = 0; i < W + 1; i++) begin
            tick();
        end
        #1;
        check("mid state", 32'(dbg_state), 32'(ST_HIGH));
        check("mid we_n",  32'(sram_we_n), 32'd0);
        check("mid oe",    32'(sram_dq_oe), 32'd1);
        rst = 1'b0;
        #1;
        check("arst state",  32'(dbg_state), 32'(ST_IDLE));
        check("arst result", mem_result, 32'd0);
        check_idle_pins("arst");
        mem_w_en = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        #1;
        check("post ready", 32'(ready), 32'd1);
        check("post state", 32'(dbg_state), 32'(ST_IDLE));
        check_idle_pins("post");
        mem_r_en = 1'b1;
        #1;
        check("post req ready", 32'(ready), 32'd0);
        mem_r_en = 1'b0;
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the run always ends
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule : tb_mem_stage_sram
